// File: rtl/count_pkg.sv
// ============================================================================
// Module      : count_pkg
// Description : Shared state encoding and default sizing for count_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_pkg;

    localparam int DEF_WIDTH    = 6;
    localparam int DEF_TICK_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/count_sequencer_if.sv
// ============================================================================
// Module      : count_sequencer_if
// Description : Control and status bundle between control logic and sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface count_sequencer_if
    import count_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             start_i;
    logic             clear_i;
    logic             pause_i;
    logic [WIDTH-1:0] start_val_i;
    logic [WIDTH-1:0] stop_val_i;
    logic [WIDTH-1:0] count_out_o;
    logic             busy_o;
    logic             done_o;
    logic             match_o;

    modport master (
        output start_i, clear_i, pause_i, start_val_i, stop_val_i,
        input  count_out_o, busy_o, done_o, match_o
    );

    modport slave (
        input  start_i, clear_i, pause_i, start_val_i, stop_val_i,
        output count_out_o, busy_o, done_o, match_o
    );

endinterface

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module      : tick_prescaler
// Description : Divides clk into a one-cycle step strobe every TICK_DIV cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler #(
    parameter int TICK_DIV = 4
) (
    input  wire  clk,
    input  wire  rst_n,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Holding the count when disabled lets a pause resume mid-period.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = enable_i && !clear_i && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/count_sequencer.sv
// ============================================================================
// Module      : count_sequencer
// Description : Steps a count from a start to a stop value once per prescaled
//               tick. Optional macro AUTO_RELOAD_EN repeats the sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_sequencer
    import count_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  wire              clk,
    input  wire              rst_n,
    count_sequencer_if.slave bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] stop_q,  stop_d;
    logic             done_q,  done_d;
    logic             match_q, match_d;
    logic             busy_q,  busy_d;

    logic             w_start_take;
    logic             w_step_en;
    logic             w_tick;
    logic [WIDTH-1:0] w_next_cnt;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] start_q, start_d;

    // Sitting on the stop value in RUN means the previous tick hit it.
    assign w_next_cnt = (count_q == stop_q) ? start_q : count_q + 1'b1;
`else
    assign w_next_cnt = count_q + 1'b1;
`endif

    assign w_start_take = !bus.clear_i && bus.start_i &&
                          ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Counting on the PAUSED->RUN edge keeps the delay equal to the pause length.
    assign w_step_en = !bus.clear_i && !bus.pause_i &&
                       ((state_q == ST_RUN) || (state_q == ST_PAUSED));

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable_i (w_step_en),
        .clear_i  (bus.clear_i || w_start_take),
        .tick_o   (w_tick)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        stop_d  = stop_q;
        done_d  = 1'b0;
        match_d = match_q;
`ifdef AUTO_RELOAD_EN
        start_d = start_q;
`endif

        if (bus.clear_i) begin
            state_d = ST_IDLE;
            count_d = '0;
            match_d = 1'b0;
        end else if (w_start_take) begin
            stop_d  = bus.stop_val_i;
            count_d = bus.start_val_i;
            match_d = 1'b0;
            state_d = ST_RUN;
`ifdef AUTO_RELOAD_EN
            start_d = bus.start_val_i;
            if (bus.start_val_i == bus.stop_val_i) begin
                done_d = 1'b1;
            end
`else
            if (bus.start_val_i == bus.stop_val_i) begin
                done_d  = 1'b1;
                match_d = 1'b1;
                state_d = ST_DONE;
            end
`endif
        end else begin
            unique case (state_q)
                ST_RUN:    if (bus.pause_i)  state_d = ST_PAUSED;
                ST_PAUSED: if (!bus.pause_i) state_d = ST_RUN;
                default:   ;
            endcase

            if (w_tick) begin
                count_d = w_next_cnt;
                if (w_next_cnt == stop_q) begin
                    done_d = 1'b1;
`ifndef AUTO_RELOAD_EN
                    match_d = 1'b1;
                    state_d = ST_DONE;
`endif
                end
            end
        end

        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            stop_q  <= '0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef AUTO_RELOAD_EN
            start_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
            match_q <= match_d;
            busy_q  <= busy_d;
`ifdef AUTO_RELOAD_EN
            start_q <= start_d;
`endif
        end
    end

    assign bus.count_out_o = count_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.match_o     = match_q;

endmodule

`default_nettype wire

// File: tb/tb_count_sequencer.sv
// ============================================================================
// Module      : tb_count_sequencer
// Description : Scoreboard bench; expected Done events come from the latency
//               rule ((stop-start) mod 2^W)*TICK_DIV plus pause cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_sequencer;

    localparam int W   = 6;
    localparam int TD  = 4;
    localparam int MOD = 1 << W;
`ifdef AUTO_RELOAD_EN
    localparam logic EXP_MATCH = 1'b0;
    localparam logic EXP_BUSY  = 1'b1;
`else
    localparam logic EXP_MATCH = 1'b1;
    localparam logic EXP_BUSY  = 1'b0;
`endif

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    count_sequencer_if #(.WIDTH(W)) bus ();

    count_sequencer #(
        .WIDTH    (W),
        .TICK_DIV (TD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every Done pulse must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (bus.done_o === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", {31'd0, bus.done_o}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("done_count", {26'd0, bus.count_out_o}, e.cnt);
                    check("done_match", {31'd0, bus.match_o}, {31'd0, EXP_MATCH});
                    check("done_busy",  {31'd0, bus.busy_o},  {31'd0, EXP_BUSY});
                end
            end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
                e = sb.pop_front();
                check("missing_done_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic int latency(input int sv, input int ev);
        return ((ev - sv + MOD) % MOD) * TD;
    endfunction

    task automatic expect_done(input int edge_no, input int cnt);
        sb.push_back(exp_t'{cyc: edge_no, cnt: cnt});
    endtask

    task automatic wait_drain();
        int t = 0;
        while (sb.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            check("done_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // Start a transaction, optionally poke a stray Start and hold Pause for p cycles.
    task automatic run_txn(input int sv, input int ev, input int p, input bit extra);
        bus.start_val_i = W'(sv);
        bus.stop_val_i  = W'(ev);
        bus.start_i     = 1'b1;
        expect_done(cyc + 1 + latency(sv, ev) + p, ev);
        @(negedge clk);
        bus.start_i = 1'b0;
        if (extra) begin
            bus.start_i     = 1'b1;
            bus.start_val_i = W'($urandom);
            bus.stop_val_i  = W'($urandom);
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        if (p > 0) begin
            bus.pause_i = 1'b1;
            repeat (p) @(negedge clk);
            bus.pause_i = 1'b0;
        end
        wait_drain();
`ifndef AUTO_RELOAD_EN
        check("match_hold", {31'd0, bus.match_o}, 32'd1);
        check("busy_after", {31'd0, bus.busy_o},  32'd0);
`endif
    endtask

    initial begin
        int s;
        rst_n           = 1'b0;
        bus.start_i     = 1'b0;
        bus.clear_i     = 1'b0;
        bus.pause_i     = 1'b0;
        bus.start_val_i = '0;
        bus.stop_val_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_count", {26'd0, bus.count_out_o}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy_o},  32'd0);
        check("rst_done",  {31'd0, bus.done_o},  32'd0);
        check("rst_match", {31'd0, bus.match_o}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef AUTO_RELOAD_EN
        bus.start_val_i = 6'd2;
        bus.stop_val_i  = 6'd4;
        bus.start_i     = 1'b1;
        s = cyc + 1;
        expect_done(s + 8, 4);
        expect_done(s + 20, 4);
        expect_done(s + 32, 4);
        @(negedge clk);
        bus.start_i = 1'b0;
        check("ar_first_count", {26'd0, bus.count_out_o}, 32'd2);
        repeat (12) @(negedge clk);
        check("ar_reload_count", {26'd0, bus.count_out_o}, 32'd2);
        check("ar_match_low",    {31'd0, bus.match_o}, 32'd0);
        wait_drain();
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        check("ar_clear_busy", {31'd0, bus.busy_o}, 32'd0);

        bus.start_val_i = 6'd9;
        bus.stop_val_i  = 6'd9;
        bus.start_i     = 1'b1;
        s = cyc + 1;
        expect_done(s, 9);
        expect_done(s + 4, 9);
        expect_done(s + 8, 9);
        @(negedge clk);
        bus.start_i = 1'b0;
        wait_drain();
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        check("ar_clear_count", {26'd0, bus.count_out_o}, 32'd0);
`else
        // Directed: 3 -> 7 with step-by-step count checks.
        bus.start_val_i = 6'd3;
        bus.stop_val_i  = 6'd7;
        bus.start_i     = 1'b1;
        expect_done(cyc + 1 + 16, 7);
        @(negedge clk);
        bus.start_i = 1'b0;
        check("t1_load_count", {26'd0, bus.count_out_o}, 32'd3);
        check("t1_busy",       {31'd0, bus.busy_o},      32'd1);
        repeat (4) @(negedge clk);
        check("t1_step1", {26'd0, bus.count_out_o}, 32'd4);
        repeat (4) @(negedge clk);
        check("t1_step2", {26'd0, bus.count_out_o}, 32'd5);
        wait_drain();
        check("t1_match", {31'd0, bus.match_o}, 32'd1);

        run_txn(62, 1, 0, 1'b0);
        run_txn(5, 5, 0, 1'b0);
        run_txn(3, 7, 10, 1'b1);

        for (int i = 0; i < 16; i++) begin
            int sv, ev, d, p;
            bit ex;
            sv = $urandom_range(0, MOD - 1);
            ev = ($urandom_range(0, 3) == 0) ? sv : $urandom_range(0, MOD - 1);
            d  = (ev - sv + MOD) % MOD;
            p  = (d >= 2) ? $urandom_range(0, 12) : 0;
            ex = (d >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_txn(sv, ev, p, ex);
        end
`endif

        // Clear mid-run: count returns to 0 and no Done follows.
        bus.start_val_i = 6'd0;
        bus.stop_val_i  = 6'd20;
        bus.start_i     = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (40) @(negedge clk);
        check("clr_pre_count", {26'd0, bus.count_out_o}, 32'd10);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
        check("clr_count", {26'd0, bus.count_out_o}, 32'd0);
        check("clr_busy",  {31'd0, bus.busy_o},  32'd0);
        check("clr_done",  {31'd0, bus.done_o},  32'd0);
        repeat (100) @(negedge clk);

        // Asynchronous reset mid-run, sampled between clock edges.
        bus.start_i = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", {26'd0, bus.count_out_o}, 32'd0);
        check("arst_busy",  {31'd0, bus.busy_o},  32'd0);
        check("arst_done",  {31'd0, bus.done_o},  32'd0);
        check("arst_match", {31'd0, bus.match_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifndef AUTO_RELOAD_EN
        // Start and Pause together from IDLE: Start wins, pause counts from the next edge.
        bus.start_val_i = 6'd10;
        bus.stop_val_i  = 6'd12;
        bus.start_i     = 1'b1;
        bus.pause_i     = 1'b1;
        expect_done(cyc + 1 + 8 + 4, 12);
        @(negedge clk);
        bus.start_i = 1'b0;
        check("sp_busy", {31'd0, bus.busy_o}, 32'd1);
        repeat (4) @(negedge clk);
        bus.pause_i = 1'b0;
        wait_drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
